// File: rtl/hilo_mdu.sv
// hilo_mdu: multiply/divide unit that owns the HI/LO register pair.
//
// A request is accepted in IDLE when start=1. The operands are captured,
// and busy stays high for the length of the operation: MUL_CYCLES cycles
// for MULT/MULTU, or 33 cycles for DIV/DIVU (32 restoring steps plus one
// sign-fix cycle). On the final busy edge the result is written into
// HI/LO, and done pulses for one cycle. The pipeline can also write HI/LO
// directly. When a direct write lands on the same edge as a completion,
// the MDU result takes priority.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous active-high reset
//   start               operation request (ignored while busy)
//   op[1:0]             00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b [31:0]         operands (a = dividend, b = divisor)
//   busy                operation in flight
//   done                one-cycle pulse, HI/LO just updated by the MDU
//   hi_write, lo_write  direct write enables for HI / LO
//   hi_data, lo_data    direct write data
//   hi, lo [31:0]       HI/LO register contents (no bypass)
module hilo_mdu #(
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  input  logic        hi_write,
  input  logic        lo_write,
  input  logic [31:0] hi_data,
  input  logic [31:0] lo_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        done_q;

  logic [31:0] a_q;         // raw dividend / multiplicand
  logic [31:0] b_q;         // raw multiplier
  logic        signed_q;    // MULT or DIV
  logic        qneg_q;      // quotient must be negated at sign fix
  logic        rneg_q;      // remainder must be negated at sign fix
  logic [31:0] quo_q;       // dividend magnitude shifting out, quotient shifting in
  logic [31:0] rem_q;       // partial remainder
  logic [31:0] dvs_q;       // divisor magnitude
  logic [31:0] hi_q, lo_q;

  logic        accept;
  logic        mul_last, div_last, complete;
  logic        div_signed;
  logic [31:0] mag_a, mag_b;
  logic [32:0] rem_shift, rem_diff;
  logic        rem_ge;
  logic [31:0] step_rem, step_quo;
  logic [31:0] q_fix, r_fix;
  logic [63:0] product;

  assign accept     = (state_q == S_IDLE) && start;
  assign mul_last   = (state_q == S_MUL) && (cnt_q == 6'(MUL_CYCLES - 1));
  assign div_last   = (state_q == S_DIV) && (cnt_q == 6'd32);
  assign complete   = mul_last || div_last;

  // Operand magnitudes for the divider, taken straight from the input pins
  // at acceptance. Negating 0x80000000 gives 0x80000000, which is the
  // correct unsigned magnitude.
  assign div_signed = ~op[0];
  assign mag_a      = (div_signed && a[31]) ? (~a + 32'd1) : a;
  assign mag_b      = (div_signed && b[31]) ? (~b + 32'd1) : b;

  // One restoring step. The shifted remainder is less than twice the
  // divisor, so a borrow out of bit 32 means "did not fit".
  assign rem_shift  = {rem_q, quo_q[31]};
  assign rem_diff   = rem_shift - {1'b0, dvs_q};
  assign rem_ge     = ~rem_diff[32];
  assign step_rem   = rem_ge ? rem_diff[31:0] : rem_shift[31:0];
  assign step_quo   = {quo_q[30:0], rem_ge};

  assign q_fix      = qneg_q ? (~quo_q + 32'd1) : quo_q;
  assign r_fix      = rneg_q ? (~rem_q + 32'd1) : rem_q;

  // Sign- or zero-extend to 64 bits. The low 64 bits of the product are
  // then exact for both the signed and the unsigned case.
  assign product = $signed({{32{signed_q & a_q[31]}}, a_q}) *
                   $signed({{32{signed_q & b_q[31]}}, b_q});

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = op[1] ? S_DIV : S_MUL;
          cnt_d   = 6'd0;
        end
      end
      S_MUL: begin
        if (mul_last) begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DIV: begin
        if (div_last) begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state_q != S_IDLE);
    done = done_q;
  end

  // done is high in the cycle after the completion edge. By then the state
  // is already IDLE, so done and busy can never overlap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= complete;
    end
  end

  // ---------------- operand capture and divider datapath ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      signed_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      quo_q    <= 32'd0;
      rem_q    <= 32'd0;
      dvs_q    <= 32'd0;
    end else if (accept) begin
      a_q      <= a;
      b_q      <= b;
      signed_q <= div_signed;
      qneg_q   <= div_signed & (a[31] ^ b[31]);
      rneg_q   <= div_signed & a[31];
      quo_q    <= mag_a;
      rem_q    <= 32'd0;
      dvs_q    <= mag_b;
    end else if ((state_q == S_DIV) && !cnt_q[5]) begin
      rem_q <= step_rem;
      quo_q <= step_quo;
    end
  end

  // ---------------- HI/LO registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (complete) begin
      if (state_q == S_MUL) begin
        hi_q <= product[63:32];
        lo_q <= product[31:0];
      end else if (dvs_q == 32'd0) begin
        // Divide by zero: the quotient saturates and the raw dividend is
        // returned, whatever the signedness.
        hi_q <= a_q;
        lo_q <= 32'hFFFF_FFFF;
      end else begin
        hi_q <= r_fix;
        lo_q <= q_fix;
      end
    end else begin
      if (hi_write) hi_q <= hi_data;
      if (lo_write) lo_q <= lo_data;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
module tb_hilo_mdu;

  localparam int MC = 3;
  localparam int DC = 33;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done;
  logic        hi_write = 1'b0;
  logic        lo_write = 1'b0;
  logic [31:0] hi_data = 32'd0;
  logic [31:0] lo_data = 32'd0;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t sb[$];

  hilo_mdu #(.MUL_CYCLES(MC)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi_write (hi_write),
    .lo_write (lo_write),
    .hi_data  (hi_data),
    .lo_data  (lo_data),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Reference model: {HI, LO} for each operation.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    int     q, m;
    logic [63:0] r;
    r = 64'd0;
    case (o)
      2'b00: begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = 64'(sx * sy);
      end
      2'b01: r = {32'd0, x} * {32'd0, y};
      2'b10: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else begin
          q = $signed(x) / $signed(y);
          m = $signed(x) % $signed(y);
          r = {m, q};
        end
      end
      default: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else r = {32'(x % y), 32'(x / y)};
      end
    endcase
    return r;
  endfunction

  // Scoreboard consumer: runs forked from the main initial block.
  task automatic monitor();
    int   bcnt;
    exp_t e;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bcnt = 0;
      end else begin
        checks++;
        if (busy && done) begin
          errors++;
          $display("FAIL busy_done_overlap busy=%0b done=%0b required not both high", busy, done);
        end
        if (busy) bcnt++;
        if (done) begin
          done_cnt++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done hi=%h lo=%h required no done pulse", hi, lo);
          end else begin
            e = sb.pop_front();
            if (hi !== e.hi || lo !== e.lo) begin
              errors++;
              $display("FAIL result hi=%h lo=%h required hi=%h lo=%h", hi, lo, e.hi, e.lo);
            end
            checks++;
            if (bcnt !== e.lat) begin
              errors++;
              $display("FAIL latency busy_cycles=%0d required %0d", bcnt, e.lat);
            end
            $display("done: hi=%h lo=%h busy_cycles=%0d", hi, lo, bcnt);
          end
          bcnt = 0;
        end
      end
    end
  endtask

  // Drive start for one edge, starting now; operands are scrambled afterwards.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp_hilo, input bit push);
    exp_t e;
    if (push) begin
      e.hi  = exp_hilo[63:32];
      e.lo  = exp_hilo[31:0];
      e.lat = o[1] ? DC : MC;
      sb.push_back(e);
    end
    $display("issue: op=%0d a=%h b=%h expect hi=%h lo=%h", o, x, y, exp_hilo[63:32], exp_hilo[31:0]);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout done=%b required 1 within %0d cycles", done, budget);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL post_reset_idle busy=%b hi=%h lo=%h required 0 0 0", busy, hi, lo);
    end
  endtask

  task automatic test_mult();
    @(posedge clk); #1;
    issue(2'b00, 32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 1'b1);
    wait_done(20);
    @(posedge clk); #1;
    issue(2'b01, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'hFFFF_FFFE}, 1'b1);
    wait_done(20);
  endtask

  task automatic test_div();
    @(posedge clk); #1;
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1);
    wait_done(50);
    @(posedge clk); #1;
    issue(2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1);
    wait_done(50);
  endtask

  task automatic test_div_special();
    @(posedge clk); #1;
    issue(2'b11, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF}, 1'b1);
    wait_done(50);
    @(posedge clk); #1;
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b1);
    wait_done(50);
    @(posedge clk); #1;
    issue(2'b10, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b1);
    wait_done(50);
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 10; i++) begin
      o = 2'($urandom);
      x = $urandom;
      y = ($urandom_range(0, 1) == 0) ? 32'($signed(32'($urandom_range(0, 40))) - 20) : $urandom;
      @(posedge clk); #1;
      issue(o, x, y, model(o, x, y), 1'b1);
      wait_done(50);
    end
  endtask

  task automatic test_lo_write();
    logic [31:0] hi_before;
    @(posedge clk); #1;
    hi_before = hi;
    lo_write  = 1'b1;
    lo_data   = 32'h1234_5678;
    #1;
    checks++;
    if (lo === 32'h1234_5678) begin
      errors++;
      $display("FAIL lo_no_bypass lo=%h required old value before edge", lo);
    end
    @(posedge clk); #1;
    lo_write = 1'b0;
    @(negedge clk);
    checks++;
    if (lo !== 32'h1234_5678 || hi !== hi_before) begin
      errors++;
      $display("FAIL lo_write lo=%h hi=%h required lo=12345678 hi=%h", lo, hi, hi_before);
    end
  endtask

  task automatic test_writeback_busy();
    @(posedge clk); #1;
    issue(2'b01, 32'd3, 32'd5, {32'd0, 32'd15}, 1'b1);
    hi_write = 1'b1; hi_data = 32'h1357_2468;
    lo_write = 1'b1; lo_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    hi_write = 1'b0; lo_write = 1'b0;
    @(negedge clk);
    checks++;
    if (hi !== 32'h1357_2468 || lo !== 32'hDEAD_BEEF || busy !== 1'b1) begin
      errors++;
      $display("FAIL write_while_busy hi=%h lo=%h busy=%b required 13572468 deadbeef 1", hi, lo, busy);
    end
    wait_done(20);
  endtask

  task automatic test_collision();
    @(posedge clk); #1;
    issue(2'b01, 32'd3, 32'd5, {32'd0, 32'd15}, 1'b1);
    repeat (MC - 1) @(posedge clk);
    #1;
    hi_write = 1'b1; hi_data = 32'hAAAA_5555;
    @(posedge clk); #1;
    hi_write = 1'b0;
    wait_done(20);
    // Same write one cycle after the completion edge now takes effect.
    hi_write = 1'b1; hi_data = 32'hAAAA_5555;
    @(posedge clk); #1;
    hi_write = 1'b0;
    @(negedge clk);
    checks++;
    if (hi !== 32'hAAAA_5555 || lo !== 32'd15) begin
      errors++;
      $display("FAIL write_after_done hi=%h lo=%h required aaaa5555 0000000f", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    issue(2'b00, 32'd7, 32'hFFFF_FFFD, model(2'b00, 32'd7, 32'hFFFF_FFFD), 1'b1);
    wait_done(20);
    issue(2'b11, 32'd1000, 32'd33, model(2'b11, 32'd1000, 32'd33), 1'b1);
    wait_done(50);
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0), 1'b1);
    wait_done(20);
  endtask

  task automatic test_busy_ignore();
    int d0;
    d0 = done_cnt;
    @(posedge clk); #1;
    issue(2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(50);
    repeat (40) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL busy_start_ignored done_pulses=%0d required %0d", done_cnt - d0, 1);
    end
  endtask

  task automatic test_reset_abort();
    int d0;
    d0 = done_cnt;
    @(posedge clk); #1;
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 64'd0, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL async_reset_abort busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    issue(2'b01, 32'd3, 32'd5, {32'd0, 32'd15}, 1'b1);
    wait_done(20);
    repeat (40) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL reset_abort_done_count done_pulses=%0d required %0d", done_cnt - d0, 1);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_mult();
    test_div();
    test_div_special();
    test_lo_write();
    test_writeback_busy();
    test_collision();
    test_back_to_back();
    test_random();
    test_busy_ignore();
    test_reset_abort();
    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
